seq_shift_add_multiplier: RTL

//  Iterative shift-add multiplier, N-bit x N-bit -> 2N-bit, one partial product per clock.

---
 rtl/seq_shift_add_multiplier.sv | 101 ++++++++++
 1 files changed

// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier: N x N -> 2N bits, one partial product per clock.
// Signed operands are reduced to magnitudes plus a sign flag when they are accepted.
// The product is negated once, on the final iteration.
module seq_shift_add_multiplier #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    input  logic           signed_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         r_state, w_state_next;
    logic [2*N-1:0] r_mag_a;    // multiplicand magnitude, pre-shifted by the iteration count
    logic [N-1:0]   r_mag_b;    // multiplier magnitude, shifted right so bit 0 is the current bit
    logic           r_neg;
    logic [2*N-1:0] r_acc;
    logic [CW-1:0]  r_cnt;
    logic [2*N-1:0] r_product;

    logic           w_accept;
    logic           w_last;
    logic [N-1:0]   w_abs_a;
    logic [N-1:0]   w_abs_b;
    logic [2*N-1:0] w_acc_next;

    assign w_accept   = in_valid && (r_state == IDLE);
    assign w_last     = (r_cnt == LAST);
    // The most negative value maps onto 2^(N-1), which still fits as an unsigned magnitude
    assign w_abs_a    = (signed_mode && A[N-1]) ? -A : A;
    assign w_abs_b    = (signed_mode && B[N-1]) ? -B : B;
    assign w_acc_next = r_acc + (r_mag_b[0] ? r_mag_a : '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_state_next = CALC;
            end
            CALC: begin
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, one add per CALC cycle, result latch on the last iteration
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mag_a   <= '0;
            r_mag_b   <= '0;
            r_neg     <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mag_a <= {{N{1'b0}}, w_abs_a};
            r_mag_b <= w_abs_b;
            r_neg   <= signed_mode && (A[N-1] ^ B[N-1]);
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (r_state == CALC) begin
            r_acc   <= w_acc_next;
            r_mag_a <= r_mag_a << 1;
            r_mag_b <= r_mag_b >> 1;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) r_product <= r_neg ? -w_acc_next : w_acc_next;
        end
    end

    assign product = r_product;

endmodule
